// File: rtl/rx_pkg.sv
// rx_pkg: shared state type and framing constants for the serial receive sequencer.
package rx_pkg;
    typedef enum logic [1:0] {IDLE, START_CHK, RECV, DONE} rx_state_t;
    localparam int RX_DEFAULT_CLKS_PER_BIT = 10;
    localparam int RX_FRAME_BITS = 9;
endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-period rollover counter, 0..CLKS_PER_BIT-1, with clear and enable.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            clear,
    input  logic                            enable,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count,
    output logic                            rollover
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] count_q, count_d;
    // rollover ignores enable so it never depends combinationally on the caller's clear/enable
    assign rollover = count_q == CW'(CLKS_PER_BIT - 1);
    assign count = count_q;
    always_comb count_d = clear ? '0 : !enable ? count_q : rollover ? '0 : count_q + 1'b1;
    always_ff @(posedge clk) begin
        if (!n_rst) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/rx_sequencer.sv
// rx_sequencer: start detection, mid-bit strobing and one-deep receive buffer for a serial RX path.
// Define RX_SEQ_SYNC_EN to place a two-flop synchronizer on serial_in.
module rx_sequencer import rx_pkg::*; #(
    parameter int CLKS_PER_BIT = RX_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    input  logic       stop_bit,
    input  logic [7:0] packet_data,
    input  logic       data_read,
    output logic       shift_strobe,
    output logic       packet_done,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    rx_state_t state_q, state_d;
    logic [3:0] strb_cnt_q, strb_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic ln, ln_q, ready_q, ready_d, fe_q, fe_d, oe_q, oe_d, commit;
    logic timer_clear, rollover;
    logic [CW-1:0] count;
`ifdef RX_SEQ_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (!n_rst) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], serial_in};
    end
    assign ln = sync_q[1];
`else
    assign ln = serial_in;
`endif
    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (timer_clear),
        .enable   (1'b1),
        .count    (count),
        .rollover (rollover)
    );
    always_comb begin
        state_d = state_q;
        strb_cnt_d = '0;
        shift_strobe = 1'b0;
        packet_done = 1'b0;
        case (state_q)
            IDLE:      if (ln_q && !ln) state_d = START_CHK;
            START_CHK: if (count == CW'(HALF - 1)) state_d = ln ? IDLE : RECV;
            RECV: begin
                strb_cnt_d = strb_cnt_q;
                if (rollover) begin
                    shift_strobe = 1'b1;
                    strb_cnt_d = strb_cnt_q + 4'd1;
                    if (strb_cnt_q == 4'(RX_FRAME_BITS - 1)) state_d = DONE;
                end
            end
            DONE: begin
                packet_done = 1'b1;
                state_d = IDLE;
            end
        endcase
        // the timer restarts from 0 on every state entry and rests while idle
        timer_clear = state_q == IDLE || state_d != state_q;
    end
    // a read coinciding with a good commit consumes the old byte, so no overrun is flagged
    always_comb begin
        commit = state_q == DONE && stop_bit;
        rx_data_d = commit ? packet_data : rx_data_q;
        ready_d = commit | (ready_q & ~data_read);
        fe_d = state_q == DONE ? ~stop_bit : fe_q;
        oe_d = commit ? ready_q & ~data_read : oe_q & ~(ready_q & data_read);
    end
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            strb_cnt_q <= '0;
            ln_q <= 1'b1;
            rx_data_q <= '0;
            ready_q <= 1'b0;
            fe_q <= 1'b0;
            oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            strb_cnt_q <= strb_cnt_d;
            ln_q <= ln;
            rx_data_q <= rx_data_d;
            ready_q <= ready_d;
            fe_q <= fe_d;
            oe_q <= oe_d;
        end
    end
    assign rx_data = rx_data_q;
    assign data_ready = ready_q;
    assign framing_error = fe_q;
    assign overrun_error = oe_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_rx_sequencer.sv
// tb_rx_sequencer: directed frames with a scoreboard of expected post-frame buffer state.
module tb_rx_sequencer;
    logic clk = 1'b0, n_rst = 1'b0, serial_in = 1'b1, data_read = 1'b0;
    logic shift_strobe, packet_done, data_ready, framing_error, overrun_error, busy;
    logic [7:0] rx_data;
    logic [8:0] sr;
    int cyc = 0, total = 0, bad = 0, tot_strb = 0;
    typedef struct {
        int         done_cyc;
        int         first;
        logic [7:0] data;
        logic       rdy, fe, oe;
    } exp_t;
    exp_t q[$];
    exp_t cur;
    logic [7:0] m_data = 8'h00;
    logic m_rdy = 1'b0, m_fe = 1'b0, m_oe = 1'b0;
    int nstrb = 0, first_c = 0, last_c = 0;
    bit pend = 0;

    rx_sequencer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .stop_bit      (sr[8]),
        .packet_data   (sr[7:0]),
        .data_read     (data_read),
        .shift_strobe  (shift_strobe),
        .packet_done   (packet_done),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) sr <= !n_rst ? 9'h1FF : shift_strobe ? {serial_in, sr[8:1]} : sr;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            nstrb = 0;
            pend = 0;
        end else begin
            if (pend) begin
                pend = 0;
                chk("rx_data", rx_data, cur.data);
                chk("data_ready", data_ready, cur.rdy);
                chk("framing_error", framing_error, cur.fe);
                chk("overrun_error", overrun_error, cur.oe);
            end
            if (shift_strobe) begin
                if (nstrb == 0) first_c = cyc;
                else chk("strobe_gap", cyc - last_c, 10);
                last_c = cyc;
                nstrb++;
                tot_strb++;
            end
            if (packet_done) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    cur = q.pop_front();
                    chk("done_cycle", cyc, cur.done_cyc);
                    chk("first_strobe", first_c, cur.first);
                    chk("strobe_count", nstrb, 9);
                    pend = 1;
                end
                nstrb = 0;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stp, input bit rd, input int ncyc);
        exp_t e;
        int e_cyc;
        e_cyc = cyc;
        if (ncyc == 100) begin
            if (stp) begin
                m_oe = m_rdy && !rd;
                m_data = b;
                m_rdy = 1'b1;
                m_fe = 1'b0;
            end else begin
                m_fe = 1'b1;
                if (rd && m_rdy) begin
                    m_rdy = 1'b0;
                    m_oe = 1'b0;
                end
            end
            e.done_cyc = e_cyc + 96;
            e.first = e_cyc + 15;
            e.data = m_data;
            e.rdy = m_rdy;
            e.fe = m_fe;
            e.oe = m_oe;
            q.push_back(e);
        end
        for (int c = 0; c < ncyc; c++) begin
            serial_in = c < 10 ? 1'b0 : c < 90 ? b[c/10-1] : stp;
            data_read = rd && c == 96;
            step(1);
        end
        data_read = 1'b0;
    endtask

    task automatic read_byte();
        data_read = 1'b1;
        step(1);
        data_read = 1'b0;
        if (m_rdy) begin
            m_rdy = 1'b0;
            m_oe = 1'b0;
        end
        chk("read_ready", data_ready, m_rdy);
        chk("read_overrun", overrun_error, m_oe);
        chk("read_data", rx_data, m_data);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int e_cyc, s0;
        step(3);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_ready", data_ready, 0);
        chk("rst_fe", framing_error, 0);
        chk("rst_oe", overrun_error, 0);
        chk("rst_busy", busy, 0);
        n_rst = 1'b1;
        step(3);
        send(8'hA5, 1'b1, 0, 100);
        serial_in = 1'b1;
        step(5);
        read_byte();
        step(3);
        s0 = tot_strb;
        e_cyc = cyc;
        serial_in = 1'b0;
        step(3);
        serial_in = 1'b1;
        step(2);
        chk("false_start_busy_e5", busy, 1);
        step(1);
        chk("false_start_idle_e6", busy, 0);
        step(20);
        chk("false_start_strobes", tot_strb - s0, 0);
        chk("false_start_ready", data_ready, 0);
        send(8'h3C, 1'b0, 0, 100);
        step(20);
        chk("low_line_no_retrigger", busy, 0);
        serial_in = 1'b1;
        step(3);
        send(8'h11, 1'b1, 0, 100);
        serial_in = 1'b1;
        step(3);
        read_byte();
        step(2);
        send(8'h12, 1'b1, 0, 100);
        serial_in = 1'b1;
        step(2);
        send(8'h34, 1'b1, 0, 100);
        serial_in = 1'b1;
        step(3);
        read_byte();
        step(2);
        send(8'h56, 1'b1, 0, 100);
        serial_in = 1'b1;
        step(2);
        send(8'h78, 1'b1, 1, 100);
        serial_in = 1'b1;
        step(3);
        read_byte();
        step(2);
        send(8'h99, 1'b1, 0, 46);
        n_rst = 1'b0;
        serial_in = 1'b1;
        step(1);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_ready", data_ready, 0);
        chk("midrst_fe", framing_error, 0);
        chk("midrst_oe", overrun_error, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_strobe", shift_strobe, 0);
        n_rst = 1'b1;
        m_data = 8'h00;
        m_rdy = 1'b0;
        m_fe = 1'b0;
        m_oe = 1'b0;
        step(3);
        send(8'h5A, 1'b1, 0, 100);
        serial_in = 1'b1;
        step(5);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_sequencer.md
# rx_sequencer

Receive-side controller that sequences the 9-bit serial-to-parallel shift register in the serial receive path. It detects a start-bit edge on the incoming line and validates it at mid-bit. It then emits one `shift_strobe` per bit period for 8 data bits plus the stop bit, pulses `packet_done`, and checks the stop bit. Good bytes are committed to a one-deep receive buffer with ready/read handshake and framing/overrun error reporting.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit. Legal values are ≥ 4.
- `clk` input 1: system clock, all state updates on rising edge.
- `n_rst` input 1: reset, synchronous and active-low.
- `serial_in` input 1: raw receive line, idle high.
- `stop_bit` input 1: stop-bit output of the shift register.
- `packet_data` input 8: data output of the shift register. LSB is the first received bit.
- `data_read` input 1: consumer read acknowledge, one-cycle pulse.
- `shift_strobe` output 1: shift enable to the shift register, one-cycle pulse per bit.
- `packet_done` output 1: one-cycle pulse; shift register holds a complete frame.
- `rx_data` output 8: buffered received byte.
- `data_ready` output 1: `rx_data` holds an unread byte.
- `framing_error` output 1: last frame had stop bit 0.
- `overrun_error` output 1: an unread byte was overwritten.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Line sample `ln` is `serial_in` after the optional synchronizer (see Configuration). `ln_q` is `ln` registered once.
- The start edge condition is `ln_q`=1 and `ln`=0.
- The bit timer counts `0..CLKS_PER_BIT-1` and clears on every state entry. HALF = `CLKS_PER_BIT/2`, integer division.
- States:
  - IDLE → START_CHK on the start edge.
  - START_CHK: when timer = HALF-1, sample `ln`.
    - `ln`=0: go to RECV.
    - `ln`=1: false start, go to IDLE, no outputs change.
  - RECV: assert `shift_strobe` when timer = CLKS_PER_BIT-1, i.e. at mid-bit. A strobe counter (0..9) counts strobes. On the 9th strobe, go to DONE.
  - DONE: one cycle. `packet_done`=1; evaluate `stop_bit`/`packet_data`. Go to IDLE.
- DONE evaluation, registered on the following edge:
  - `stop_bit`=0: `framing_error`←1; `rx_data`, `data_ready`, `overrun_error` unchanged.
  - `stop_bit`=1: `framing_error`←0; `rx_data`←`packet_data`; `data_ready`←1.
  - Overrun: `overrun_error`←1 if `data_ready` was 1 and `data_read`=0 in the DONE cycle.
- `data_read` while `data_ready`=1 and not in a committing DONE: clears `data_ready` and `overrun_error` next edge. `data_read` with `data_ready`=0 is ignored.
- Simultaneous `data_read` and a good-frame DONE: the old byte is consumed, the new byte is loaded, `data_ready` stays 1, and `overrun_error` is cleared.
- In IDLE no new frame starts until a fresh 1→0 edge is seen. A line held low after a framing error does not retrigger.

## Timing
- Let E be the cycle in which the start edge condition is true.
- Start check at cycle E+HALF.
- Strobes at cycles E+HALF+k·CLKS_PER_BIT, for k=1..9.
- `packet_done` at E+HALF+9·CLKS_PER_BIT+1.
- `data_ready`/`rx_data`/error updates visible at E+HALF+9·CLKS_PER_BIT+2.
- Earliest next start edge is accepted in the cycle after DONE.
- Reset (`n_rst`=0 at an edge), including mid-frame: state IDLE, timer and strobe count 0. All outputs 0; `rx_data`=8'h00; `ln_q`=1 so a low line at reset release is not an edge.

## Configuration
- `RX_SEQ_SYNC_EN` defined: two-flop synchronizer on `serial_in` (flops reset to 1). `ln` lags `serial_in` by 2 cycles; E and all later timing shift by +2 relative to the raw line.
- `RX_SEQ_SYNC_EN` undefined: `ln` = `serial_in` directly, for synchronous benches and internal loopback.

## Structure
- Shared package `rx_pkg`:
  - `rx_state_t` enum: IDLE, START_CHK, RECV, DONE.
  - `RX_DEFAULT_CLKS_PER_BIT` = 10.
  - `RX_FRAME_BITS` = 9.
- Sub-module `rx_bit_timer`: a parameterized rollover counter.
  - Inputs: `clear`, `enable`.
  - Outputs: `count`; one-cycle `rollover` flag at `CLKS_PER_BIT-1`.
  - Synchronous active-low reset.
- Strobe count, buffer and error flags stay in `rx_sequencer`.

## Test plan
Default `CLKS_PER_BIT`=10, macro undefined, shift register instantiated alongside.
- **Good frame:** send 0xA5 LSB-first with stop 1 → exactly 9 strobes, spaced 10 cycles apart, first at E+15; `packet_done` at E+96; `rx_data`=0xA5 and `data_ready`=1 at E+97; both errors 0.
- **False start:** 3-cycle low glitch → START_CHK returns to IDLE at E+5; zero strobes; outputs unchanged.
- **Framing error:** 0x3C with stop bit 0 → `framing_error`=1; `data_ready` stays 0; `rx_data` unchanged. A following good 0x11 sets `framing_error`=0 and `rx_data`=0x11.
- **Overrun:** two good frames 0x12, 0x34 with no `data_read` → `rx_data`=0x34, `overrun_error`=1. Then `data_read` → `data_ready`=0, `overrun_error`=0.
- **Read collision:** `data_read` pulsed in the DONE cycle of the second frame → `data_ready`=1, `overrun_error`=0, `rx_data`=new byte.
- **Reset mid-frame:** `n_rst`=0 after the 4th strobe → next edge all outputs 0, state IDLE. A full 0x5A frame sent afterwards is received correctly.
